register_file: RTL and testbench

//  32 x 32-bit architectural register file with rename tags. Sits downstream of
//  the reorder buffer's commit port and serves operand reads to the instruction unit.

---
 rtl/register_file_if.sv | 34 +++
 rtl/register_file.sv | 98 +++++++++
 tb/tb_register_file.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Commit, rename and operand-read signals between the ROB / instruction unit
// and the architectural register file.
interface register_file_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 clear;
    logic                 regUpdateValid;
    logic [4:0]           regUpdateDest;
    logic [31:0]          regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;
    logic                 renameValid;
    logic [4:0]           renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;
    logic [4:0]           rs1;
    logic [31:0]          rs1Value;
    logic                 rs1Dirty;
    logic [ROB_WIDTH-1:0] rs1Dep;
    logic [4:0]           rs2;
    logic [31:0]          rs2Value;
    logic                 rs2Dirty;
    logic [ROB_WIDTH-1:0] rs2Dep;

    modport master (
        output clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId, rs1, rs2,
        input  rs1Value, rs1Dirty, rs1Dep, rs2Value, rs2Dirty, rs2Dep
    );

    modport slave (
        input  clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId, rs1, rs2,
        output rs1Value, rs1Dirty, rs1Dep, rs2Value, rs2Dirty, rs2Dep
    );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit architectural register file with per-register rename tags
// (dirty flag + newest producer ROB index) and a commit bypass on both reads.
module register_file #(
    parameter int ROB_WIDTH = 4
) (
    input  logic               clockIn,
    input  logic               resetIn,
    register_file_if.slave     bus
);
    logic [31:0]          value_q [32];
    logic [31:0]          value_d [32];
    logic                 dirty_q [32];
    logic                 dirty_d [32];
    logic [ROB_WIDTH-1:0] dep_q   [32];
    logic [ROB_WIDTH-1:0] dep_d   [32];

    logic cmt_ok;
    logic ren_ok;
    logic hit1;
    logic hit2;

    assign cmt_ok = bus.regUpdateValid && (bus.regUpdateDest != 5'd0);
    assign ren_ok = bus.renameValid && !bus.clear && (bus.renameDest != 5'd0);

    always_comb begin
        value_d = value_q;
        dirty_d = dirty_q;
        dep_d   = dep_q;
        if (bus.clear) begin
            for (int i = 0; i < 32; i++) begin
                dirty_d[i] = 1'b0;
                dep_d[i]   = '0;
            end
        end
        if (cmt_ok) begin
            value_d[bus.regUpdateDest] = bus.regValue;
            // Only the newest producer may retire the tag; older commits are stale
            if (dirty_q[bus.regUpdateDest] &&
                dep_q[bus.regUpdateDest] == bus.regUpdateRobId) begin
                dirty_d[bus.regUpdateDest] = 1'b0;
                dep_d[bus.regUpdateDest]   = '0;
            end
        end
        if (ren_ok) begin
            dirty_d[bus.renameDest] = 1'b1;
            dep_d[bus.renameDest]   = bus.renameRobId;
        end
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            for (int i = 0; i < 32; i++) begin
                value_q[i] <= '0;
                dirty_q[i] <= 1'b0;
                dep_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            dirty_q <= dirty_d;
            dep_q   <= dep_d;
        end
    end

    assign hit1 = cmt_ok && (bus.regUpdateDest == bus.rs1) &&
                  dirty_q[bus.rs1] && (dep_q[bus.rs1] == bus.regUpdateRobId);
    assign hit2 = cmt_ok && (bus.regUpdateDest == bus.rs2) &&
                  dirty_q[bus.rs2] && (dep_q[bus.rs2] == bus.regUpdateRobId);

    always_comb begin
        bus.rs1Value = value_q[bus.rs1];
        bus.rs1Dirty = dirty_q[bus.rs1];
        bus.rs1Dep   = dep_q[bus.rs1];
        if (bus.rs1 == 5'd0) begin
            bus.rs1Value = '0;
            bus.rs1Dirty = 1'b0;
            bus.rs1Dep   = '0;
        end else if (hit1) begin
            bus.rs1Value = bus.regValue;
            bus.rs1Dirty = 1'b0;
            bus.rs1Dep   = '0;
        end
    end

    always_comb begin
        bus.rs2Value = value_q[bus.rs2];
        bus.rs2Dirty = dirty_q[bus.rs2];
        bus.rs2Dep   = dep_q[bus.rs2];
        if (bus.rs2 == 5'd0) begin
            bus.rs2Value = '0;
            bus.rs2Dirty = 1'b0;
            bus.rs2Dep   = '0;
        end else if (hit2) begin
            bus.rs2Value = bus.regValue;
            bus.rs2Dirty = 1'b0;
            bus.rs2Dep   = '0;
        end
    end
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table for the corner cases,
// then random traffic checked against an array-based reference model.
module tb_register_file;
    logic clk;
    logic rst_n;

    register_file_if #(.ROB_WIDTH(4)) bus ();

    register_file #(.ROB_WIDTH(4)) dut (
        .clockIn (clk),
        .resetIn (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        clr;
        logic        cv;
        logic [4:0]  cd;
        logic [31:0] cval;
        logic [3:0]  cid;
        logic        rv;
        logic [4:0]  rd;
        logic [3:0]  rid;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        chk;
        logic [31:0] v1;
        logic        d1;
        logic [3:0]  p1;
        logic [31:0] v2;
        logic        d2;
        logic [3:0]  p2;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mval   [32];
    logic        mdirty [32];
    logic [3:0]  mdep   [32];

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rn, input logic clr,
        input logic cv, input logic [4:0] cd, input logic [31:0] cval,
        input logic [3:0] cid,
        input logic rv, input logic [4:0] rd, input logic [3:0] rid,
        input logic [4:0] a1, input logic [4:0] a2, input logic chk,
        input logic [31:0] v1, input logic d1, input logic [3:0] p1,
        input logic [31:0] v2, input logic d2, input logic [3:0] p2);
        vec_t v;
        v.rst_n = rn; v.clr = clr;
        v.cv = cv; v.cd = cd; v.cval = cval; v.cid = cid;
        v.rv = rv; v.rd = rd; v.rid = rid;
        v.a1 = a1; v.a2 = a2; v.chk = chk;
        v.v1 = v1; v.d1 = d1; v.p1 = p1;
        v.v2 = v2; v.d2 = d2; v.p2 = p2;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_n              = v.rst_n;
        bus.clear          = v.clr;
        bus.regUpdateValid = v.cv;
        bus.regUpdateDest  = v.cd;
        bus.regValue       = v.cval;
        bus.regUpdateRobId = v.cid;
        bus.renameValid    = v.rv;
        bus.renameDest     = v.rd;
        bus.renameRobId    = v.rid;
        bus.rs1            = v.a1;
        bus.rs2            = v.a2;
    endtask

    // Reference semantics: what a reader sees this cycle
    task automatic mread(input vec_t v, input logic [4:0] a,
                         output logic [31:0] rv, output logic rd,
                         output logic [3:0] rp);
        if (a == 5'd0) begin
            rv = 0; rd = 0; rp = 0;
        end else if (v.cv && v.cd == a && mdirty[a] && mdep[a] == v.cid) begin
            rv = v.cval; rd = 0; rp = 0;
        end else begin
            rv = mval[a]; rd = mdirty[a]; rp = mdep[a];
        end
    endtask

    task automatic mupdate(input vec_t v);
        if (!v.rst_n) begin
            for (int i = 0; i < 32; i++) begin
                mval[i] = 0; mdirty[i] = 0; mdep[i] = 0;
            end
        end else begin
            if (v.cv && v.cd != 0) begin
                mval[v.cd] = v.cval;
                if (mdirty[v.cd] && mdep[v.cd] == v.cid) begin
                    mdirty[v.cd] = 0; mdep[v.cd] = 0;
                end
            end
            if (v.clr) begin
                for (int i = 0; i < 32; i++) begin
                    mdirty[i] = 0; mdep[i] = 0;
                end
            end else if (v.rv && v.rd != 0) begin
                mdirty[v.rd] = 1; mdep[v.rd] = v.rid;
            end
        end
    endtask

    task automatic cmp(input string nm, input int idx,
                       input logic [31:0] av, input logic ad, input logic [3:0] ap,
                       input logic [31:0] ev, input logic ed, input logic [3:0] ep);
        n_cmp++;
        if (av !== ev || ad !== ed || ap !== ep) begin
            n_bad++;
            $display("FAIL %s #%0d: got val=%h dirty=%b dep=%0d, want val=%h dirty=%b dep=%0d",
                     nm, idx, av, ad, ap, ev, ed, ep);
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] ev;
        logic        ed;
        logic [3:0]  ep;
        logic [4:0]  r;

        v = mk(0,0, 0,0,0,0, 0,0,0, 0,0, 0, 0,0,0, 0,0,0);
        drive(v);
        for (int i = 0; i < 32; i++) begin
            mval[i] = 0; mdirty[i] = 0; mdep[i] = 0;
        end

        //        rn clr cv cd val          cid rv rd rid a1 a2 chk v1 d1 p1 v2 d2 p2
        tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0, 5,31, 0, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,31, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,5,3, 5,31, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,31, 1, 0,1,3, 0,0,0));
        tbl.push_back(mk(1,0, 1,5,32'hDEADBEEF,3, 0,0,0, 5,5, 1,
                         32'hDEADBEEF,0,0, 32'hDEADBEEF,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,0, 1, 32'hDEADBEEF,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,5,3, 5,0, 1, 32'hDEADBEEF,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,5,7, 5,0, 1, 32'hDEADBEEF,1,3, 0,0,0));
        tbl.push_back(mk(1,0, 1,5,1,3, 0,0,0, 5,0, 1, 32'hDEADBEEF,1,7, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,0, 1, 1,1,7, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,6,2, 5,6, 1, 1,1,7, 0,0,0));
        tbl.push_back(mk(1,0, 1,6,32'h55,2, 1,6,9, 5,6, 1, 1,1,7, 32'h55,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,6, 1, 1,1,7, 32'h55,1,9));
        tbl.push_back(mk(1,0, 1,0,5,4, 1,0,4, 0,6, 1, 0,0,0, 32'h55,1,9));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 0,0, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,1,1, 1,2, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,2,2, 1,2, 1, 0,1,1, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 1,3,3, 1,2, 1, 0,1,1, 0,1,2));
        tbl.push_back(mk(1,1, 1,1,32'hA,1, 1,4,5, 1,3, 1, 32'hA,0,0, 0,1,3));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 1,4, 1, 32'hA,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 2,3, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,6, 1, 1,0,0, 32'h55,0,0));
        tbl.push_back(mk(1,1, 1,7,32'h77,0, 0,0,0, 7,6, 1, 0,0,0, 32'h55,0,0));
        tbl.push_back(mk(0,0, 1,8,32'h88,0, 1,9,1, 7,8, 1, 32'h77,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 5,6, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 7,9, 1, 0,0,0, 0,0,0));
        tbl.push_back(mk(1,0, 0,0,0,0, 0,0,0, 1,8, 1, 0,0,0, 0,0,0));

        @(posedge clk);
        #1;
        foreach (tbl[k]) begin
            drive(tbl[k]);
            @(negedge clk);
            if (tbl[k].chk) begin
                cmp("dir_rs1", k, bus.rs1Value, bus.rs1Dirty, bus.rs1Dep,
                    tbl[k].v1, tbl[k].d1, tbl[k].p1);
                cmp("dir_rs2", k, bus.rs2Value, bus.rs2Dirty, bus.rs2Dep,
                    tbl[k].v2, tbl[k].d2, tbl[k].p2);
            end
            @(posedge clk);
            mupdate(tbl[k]);
            #1;
        end

        for (int n = 0; n < 3000; n++) begin
            v = mk(1,0, 0,0,0,0, 0,0,0, 0,0, 0, 0,0,0, 0,0,0);
            v.rst_n = ($urandom_range(0, 199) != 0);
            v.clr   = ($urandom_range(0, 39) == 0);
            v.cv    = ($urandom_range(0, 1) == 1);
            r = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) begin
                for (int t = 0; t < 8; t++) begin
                    if (!mdirty[r]) r = 5'($urandom_range(0, 31));
                end
            end
            v.cd   = r;
            v.cval = $urandom;
            v.cid  = ($urandom_range(0, 3) != 0) ? mdep[r] : 4'($urandom_range(0, 15));
            v.rv   = ($urandom_range(0, 1) == 1);
            v.rd   = ($urandom_range(0, 3) == 0) ? r : 5'($urandom_range(0, 31));
            v.rid  = 4'($urandom_range(0, 15));
            v.a1   = ($urandom_range(0, 1) == 1) ? r : 5'($urandom_range(0, 31));
            v.a2   = 5'($urandom_range(0, 31));
            drive(v);
            @(negedge clk);
            mread(v, v.a1, ev, ed, ep);
            cmp("rnd_rs1", n, bus.rs1Value, bus.rs1Dirty, bus.rs1Dep, ev, ed, ep);
            mread(v, v.a2, ev, ed, ep);
            cmp("rnd_rs2", n, bus.rs2Value, bus.rs2Dirty, bus.rs2Dep, ev, ed, ep);
            @(posedge clk);
            mupdate(v);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
